mcpu_bus_arb: RTL and testbench
===============================

# mcpu_bus_arb

Parametrised N-master bus arbiter and MIO handshake engine for the multi-cycle CPU memory/IO bus. It lets `N_MASTERS` requesters (CPU core, DMA, debug port) share one memory/IO port that uses the existing `Addr_out`/`Data_out`/`mem_w`/`CPU_MIO`/`MIO_ready` signalling. It performs round-robin arbitration, latches each transaction, and waits on `MIO_ready` with an optional timeout. It sits between the CPU tops and the memory/IO subsystem.

## Interface
- `N_MASTERS`, 2, number of requesters (≥1)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, bus cycles waited for `MIO_ready` before error (≥1; used only with timeout enabled)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `m_req`  in  N_MASTERS  per-master request, held high until that master's `m_ready`
- `m_we`  in  N_MASTERS  per-master write enable (1 = write)
- `m_addr`  in  N_MASTERS*ADDR_W  packed; master i at `[i*ADDR_W +: ADDR_W]`
- `m_wdata`  in  N_MASTERS*DATA_W  packed likewise
- `m_rdata`  out  DATA_W  shared read data, valid while any `m_ready` bit is high
- `m_ready`  out  N_MASTERS  one-hot, one-cycle completion pulse
- `m_err`  out  N_MASTERS  one-hot, one-cycle timeout pulse, coincident with `m_ready`
- `Addr_out`  out  ADDR_W  bus address
- `Data_out`  out  DATA_W  bus write data
- `mem_w`  out  1  bus write strobe
- `CPU_MIO`  out  1  bus cycle active
- `Data_in`  in  DATA_W  bus read data
- `MIO_ready`  in  1  bus completion
- `grant`  out  max(1,clog2(N_MASTERS))  index of current or last granted master
- `state`  out  2  FSM state for debug

## Operation
- FSM states:
  - IDLE = 0
  - BUS = 1
  - RESP = 2
  - Code 3 is unused and recovers to IDLE.
- **IDLE:**
  - If any `m_req` bit is set, pick the first set bit searching upward, circularly, from `grant+1`.
  - Latch that master's addr, wdata and we into `Addr_out`/`Data_out`/`mem_w`.
  - Update `grant` and clear the wait counter, then go to BUS.
  - If no request, stay in IDLE.
- **BUS:**
  - `CPU_MIO=1`. `mem_w` equals the latched we and is forced 0 outside BUS.
  - If `MIO_ready=1`: register `Data_in` into `m_rdata` (also on writes), then go to RESP.
  - Otherwise increment the wait counter.
- **RESP:**
  - `CPU_MIO=0`. Assert `m_ready[grant]` (and `m_err[grant]` if the error flag is set) for exactly one cycle.
  - Go to IDLE.
- `Addr_out`/`Data_out` hold their latched values outside BUS.
- Round-robin rule: the master just served has lowest priority at the next arbitration, so there is no starvation.
- `N_MASTERS=1`: `grant` is a constant 0 and the arbiter degenerates to a pass-through.
- Masters must hold `m_addr`/`m_wdata`/`m_we` stable only during the IDLE cycle in which they are granted. Later changes have no effect on the in-flight transaction.

## Timing
- Reset values:
  - state IDLE
  - `grant = N_MASTERS-1`, so master 0 wins first
  - `Addr_out`, `Data_out`, `m_rdata` = 0
  - `mem_w`, `CPU_MIO`, `m_ready`, `m_err` = 0
  - counter and error flag = 0
- Zero-wait transaction: request seen in IDLE cycle t, BUS at t+1 (`MIO_ready` sampled there), `m_ready` at t+2, back in IDLE at t+3.
- With w wait states, `m_ready` arrives at t+2+w.
- Back-to-back: a master that keeps `m_req` high after `m_ready` is treated as issuing a new request.
- Reset mid-transaction (any state): state returns to IDLE on the next edge. The aborted request gets no `m_ready` or `m_err`, and the pointer is reset.

## Configuration
- Timeout is enabled by macro `MCPU_BUS_TIMEOUT_EN`.
- **Macro defined:**
  - In BUS, if `MIO_ready=0` and the counter equals `TIMEOUT-1`: set the error flag, load `m_rdata` with all-ones, and go to RESP.
  - Timeout is therefore reached after `TIMEOUT` BUS cycles without ready.
  - If `MIO_ready` and the final count occur in the same cycle, `MIO_ready` wins and the transaction completes normally.
- **Macro undefined:**
  - The counter and flag are not built, and `m_err` is tied to 0.
  - BUS waits indefinitely for `MIO_ready`.

## Structure
- Package `mcpu_bus_pkg`: state encoding constants (IDLE/BUS/RESP), the all-ones error data constant, and a `clog2`-based grant width function.
- One sub-module, `mcpu_rr_arbiter`:
  - Combinational round-robin pick from request vector + last grant.
  - Outputs a one-hot grant and a valid flag.
  - Instantiated once.

## Test plan
- **Zero-wait read:** m0 reads addr 0x0000_0040, memory returns 0x1234_5678 with `MIO_ready` high in its first BUS cycle. Expect `m_ready=2'b01` at t+2, `m_rdata=0x1234_5678`, `mem_w` never high.
- **Write with 3 wait states:** m1 writes 0xDEAD_BEEF to 0x0000_0100. Expect `mem_w=1` and `CPU_MIO=1` for 4 BUS cycles with stable addr/data, then `m_ready=2'b10` at t+5.
- **Contention:** both masters hold `m_req` from reset with zero-wait memory. Expect `grant` sequence 0,1,0,1, and each `m_ready` every 6 cycles.
- **Timeout:** `TIMEOUT=4`, macro defined, `MIO_ready` held 0. Expect `m_ready[0]=m_err[0]=1` after 4 BUS cycles and `m_rdata=0xFFFF_FFFF`. Repeat with `MIO_ready` rising on the 4th BUS cycle: expect normal completion and `m_err=0`.
- **Reset during BUS:** assert `reset` on the 2nd wait cycle. Expect state=IDLE, `CPU_MIO=0`, no `m_ready`/`m_err`, and the next arbitration grants master 0.

Source files
------------

// File: rtl/mcpu_bus_pkg.sv
// Shared types and constants for the multi-cycle CPU memory/IO bus arbiter.
package mcpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } bus_state_t;

    // Replicated across the data width to form the read data of a timed-out cycle.
    localparam logic ERR_DATA_BIT = 1'b1;

    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mcpu_rr_arbiter.sv
// Combinational round-robin pick: first requester above the last grant, wrapping around.
module mcpu_rr_arbiter
    import mcpu_bus_pkg::*;
#(
    parameter int N  = 2,
    parameter int GW = grant_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    logic [N-1:0] hi_pick;
    logic [N-1:0] lo_pick;
    logic         hi_hit;
    logic         lo_hit;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        hi_pick = '0;
        lo_pick = '0;
        hi_hit  = 1'b0;
        lo_hit  = 1'b0;
        // Masters above the last grant win over those at or below it (the wrap-around half).
        for (int i = 0; i < N; i++) begin
            if (req[i] && (i > int'(last)) && !hi_hit) begin
                hi_pick[i] = 1'b1;
                hi_hit     = 1'b1;
            end
            if (req[i] && (i <= int'(last)) && !lo_hit) begin
                lo_pick[i] = 1'b1;
                lo_hit     = 1'b1;
            end
        end
        gnt   = hi_hit ? hi_pick : lo_pick;
        valid = hi_hit | lo_hit;
    end

endmodule

// File: rtl/mcpu_bus_arb.sv
// N-master round-robin arbiter and MIO handshake engine for the multi-cycle CPU bus.
// The MIO_ready timeout is built only when MCPU_BUS_TIMEOUT_EN is defined.
module mcpu_bus_arb
    import mcpu_bus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_MASTERS-1:0]                m_req,
    input  logic [N_MASTERS-1:0]                m_we,
    input  logic [N_MASTERS*ADDR_W-1:0]         m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]         m_wdata,
    output logic [DATA_W-1:0]                   m_rdata,
    output logic [N_MASTERS-1:0]                m_ready,
    output logic [N_MASTERS-1:0]                m_err,
    output logic [ADDR_W-1:0]                   Addr_out,
    output logic [DATA_W-1:0]                   Data_out,
    output logic                                mem_w,
    output logic                                CPU_MIO,
    input  logic [DATA_W-1:0]                   Data_in,
    input  logic                                MIO_ready,
    output logic [grant_width(N_MASTERS)-1:0]   grant,
    output logic [1:0]                          state
);

    localparam int GW = grant_width(N_MASTERS);

    if (N_MASTERS < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mcpu_bus_arb: N_MASTERS and TIMEOUT must both be at least 1");
    end

    bus_state_t           state_q;
    logic [N_MASTERS-1:0] arb_gnt;
    logic                 arb_valid;
    logic [N_MASTERS-1:0] grant_onehot;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 sel_we;
    logic [GW-1:0]        sel_idx;

    mcpu_rr_arbiter #(
        .N  (N_MASTERS),
        .GW (GW)
    ) u_arb (
        .req   (m_req),
        .last  (grant),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (arb_gnt[i]) begin
                sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = m_wdata[i*DATA_W +: DATA_W];
                sel_we    = m_we[i];
                sel_idx   = GW'(i);
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            grant_onehot[i] = (grant == GW'(i));
        end
    end

    assign state = state_q;

`ifdef MCPU_BUS_TIMEOUT_EN
    localparam int             CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_flag;

    // Error is only visible during the single response cycle of the failed master.
    assign m_err = (state_q == ST_RESP && err_flag) ? grant_onehot : '0;
`else
    assign m_err = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant    <= GW'(N_MASTERS - 1);
            Addr_out <= '0;
            Data_out <= '0;
            m_rdata  <= '0;
            mem_w    <= 1'b0;
            CPU_MIO  <= 1'b0;
            m_ready  <= '0;
`ifdef MCPU_BUS_TIMEOUT_EN
            wait_cnt <= '0;
            err_flag <= 1'b0;
`endif
        end else begin
            m_ready <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant    <= sel_idx;
                        Addr_out <= sel_addr;
                        Data_out <= sel_wdata;
                        mem_w    <= sel_we;
                        CPU_MIO  <= 1'b1;
                        state_q  <= ST_BUS;
`ifdef MCPU_BUS_TIMEOUT_EN
                        wait_cnt <= '0;
                        err_flag <= 1'b0;
`endif
                    end
                end
                ST_BUS: begin
                    // MIO_ready takes precedence over an expiring wait counter.
                    if (MIO_ready) begin
                        m_rdata <= Data_in;
                        m_ready <= grant_onehot;
                        CPU_MIO <= 1'b0;
                        mem_w   <= 1'b0;
                        state_q <= ST_RESP;
                    end
`ifdef MCPU_BUS_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        m_rdata  <= {DATA_W{ERR_DATA_BIT}};
                        err_flag <= 1'b1;
                        m_ready  <= grant_onehot;
                        CPU_MIO  <= 1'b0;
                        mem_w    <= 1'b0;
                        state_q  <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    CPU_MIO <= 1'b0;
                    mem_w   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcpu_bus_arb.sv
// Scoreboard bench for mcpu_bus_arb: directed transactions push expected completions, a monitor pops them.
module tb_mcpu_bus_arb;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    m_req;
    logic [N-1:0]    m_we;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_ready;
    logic [N-1:0]    m_err;
    logic [AW-1:0]   Addr_out;
    logic [DW-1:0]   Data_out;
    logic            mem_w;
    logic            CPU_MIO;
    logic [DW-1:0]   Data_in;
    logic            MIO_ready;
    logic [0:0]      grant;
    logic [1:0]      state;

    logic [AW-1:0]   addr_a  [N];
    logic [DW-1:0]   wdata_a [N];

    typedef struct {
        logic        m;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    bit          never_ready = 1'b0;
    int          ready_at    = 0;
    logic [31:0] resp_data   = 32'h0;

    mcpu_bus_arb #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready),
        .m_err     (m_err),
        .Addr_out  (Addr_out),
        .Data_out  (Data_out),
        .mem_w     (mem_w),
        .CPU_MIO   (CPU_MIO),
        .Data_in   (Data_in),
        .MIO_ready (MIO_ready),
        .grant     (grant),
        .state     (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW]  = addr_a[i];
            m_wdata[i*DW +: DW] = wdata_a[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory/IO responder: raises MIO_ready in the BUS cycle numbered ready_at (0-based).
    initial begin
        int bus_k;
        bus_k     = 0;
        MIO_ready = 1'b0;
        Data_in   = '0;
        forever begin
            @(negedge clk);
            if (CPU_MIO === 1'b1) begin
                MIO_ready = !never_ready && (bus_k == ready_at);
                bus_k++;
            end else begin
                MIO_ready = 1'b0;
                bus_k     = 0;
            end
            Data_in = resp_data;
        end
    end

    // Monitor: every completion pulse must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && (m_ready !== '0 || m_err !== '0)) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 64'({m_ready, m_err}), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("ready_onehot", 64'(m_ready), 64'(e.m ? 2'b10 : 2'b01));
                    check("ready_err", 64'(m_err), 64'(e.err ? (e.m ? 2'b10 : 2'b01) : 2'b00));
                    check("ready_rdata", 64'(m_rdata), 64'(e.rdata));
                    check("ready_grant", 64'(grant), 64'(e.m));
                    check("ready_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // One transaction by master m; called #1 after a rising edge while the DUT is in IDLE.
    task automatic run_txn(input logic m, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int waits, input logic err);
        exp_t e;
        e.m     = m;
        e.err   = err;
        e.rdata = err ? 32'hFFFF_FFFF : resp_data;
        e.cyc   = cyc + 2 + waits;
        sb.push_back(e);
        never_ready = err;
        ready_at    = waits;
        addr_a[m]   = addr;
        wdata_a[m]  = wdata;
        m_we[m]     = we;
        m_req[m]    = 1'b1;
        @(negedge clk);
        check("idle_state", 64'(state), 64'(0));
        check("idle_mio", 64'(CPU_MIO), 64'(0));
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            check("bus_state", 64'(state), 64'(1));
            check("bus_mio", 64'(CPU_MIO), 64'(1));
            check("bus_mem_w", 64'(mem_w), 64'(we));
            check("bus_addr", 64'(Addr_out), 64'(addr));
            check("bus_data", 64'(Data_out), 64'(wdata));
            if (k == 0) begin
                addr_a[m]  = ~addr;
                wdata_a[m] = ~wdata;
                m_we[m]    = ~we;
            end
        end
        @(negedge clk);
        m_req[m] = 1'b0;
        check("resp_state", 64'(state), 64'(2));
        check("resp_mio", 64'(CPU_MIO), 64'(0));
        check("resp_mem_w", 64'(mem_w), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int got;
        reset  = 1'b1;
        m_req  = '0;
        m_we   = '0;
        for (int i = 0; i < N; i++) begin
            addr_a[i]  = '0;
            wdata_a[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        @(negedge clk);
        check("rst_state", 64'(state), 64'(0));
        check("rst_grant", 64'(grant), 64'(1));
        check("rst_addr", 64'(Addr_out), 64'(0));
        check("rst_data", 64'(Data_out), 64'(0));
        check("rst_rdata", 64'(m_rdata), 64'(0));
        check("rst_mem_w", 64'(mem_w), 64'(0));
        check("rst_mio", 64'(CPU_MIO), 64'(0));
        check("rst_ready", 64'(m_ready), 64'(0));
        check("rst_err", 64'(m_err), 64'(0));
        @(posedge clk);
        #1;

        resp_data = 32'h1234_5678;
        run_txn(1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 0, 1'b0);

        resp_data = 32'h0BAD_F00D;
        run_txn(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 3, 1'b0);

`ifdef MCPU_BUS_TIMEOUT_EN
        resp_data = 32'h0000_0777;
        run_txn(1'b0, 1'b0, 32'h0000_0200, 32'h0000_0000, TO - 1, 1'b1);
        run_txn(1'b0, 1'b1, 32'h0000_0204, 32'hCAFE_0004, TO - 1, 1'b0);
`else
        // Without the timeout the bus waits on MIO_ready forever; only reset ends it.
        never_ready = 1'b1;
        addr_a[0]   = 32'h0000_0300;
        m_we[0]     = 1'b0;
        m_req[0]    = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hang_state", 64'(state), 64'(1));
            check("hang_mio", 64'(CPU_MIO), 64'(1));
        end
        m_req[0] = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        resp_data = 32'h0000_0777;
        run_txn(1'b0, 1'b1, 32'h0000_0204, 32'hCAFE_0004, 3, 1'b0);
`endif

        // Reset on the second wait cycle of a master-0 transaction; grant is 0 beforehand.
        never_ready = 1'b1;
        addr_a[0]   = 32'h0000_0400;
        m_we[0]     = 1'b0;
        m_req[0]    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_state", 64'(state), 64'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_req = '0;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        never_ready = 1'b0;
        ready_at    = 0;
        resp_data   = 32'h5A5A_0001;
        addr_a[0]   = 32'h0000_0500;
        addr_a[1]   = 32'h0000_0600;
        wdata_a[1]  = 32'h0000_0066;
        m_we        = 2'b10;
        m_req       = 2'b11;
        c = cyc;
        sb.push_back('{m: 1'b0, rdata: 32'h5A5A_0001, err: 1'b0, cyc: c + 2});
        sb.push_back('{m: 1'b1, rdata: 32'h5A5A_0001, err: 1'b0, cyc: c + 5});
        sb.push_back('{m: 1'b0, rdata: 32'h5A5A_0001, err: 1'b0, cyc: c + 8});
        sb.push_back('{m: 1'b1, rdata: 32'h5A5A_0001, err: 1'b0, cyc: c + 11});
        @(negedge clk);
        check("abort_state", 64'(state), 64'(0));
        check("abort_mio", 64'(CPU_MIO), 64'(0));
        check("abort_ready", 64'(m_ready), 64'(0));
        check("abort_err", 64'(m_err), 64'(0));
        check("abort_grant", 64'(grant), 64'(1));

        // Both masters keep requesting; completions must alternate 0,1,0,1.
        got = 0;
        for (int k = 0; k < 40 && got < 4; k++) begin
            if (m_ready !== '0) got++;
            if (got < 4) @(negedge clk);
        end
        m_req = '0;
        check("contention_count", 64'(got), 64'(4));

        repeat (5) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
